// File: rtl/of_stage_p.sv
// ---------------------------------------------------------------------------
// of_stage_p : SimpleRisc operand-fetch stage.
//
// Holds the architectural register file. It has one writeback write port and
// two read ports. Each read port can optionally forward the writeback value
// in the same cycle. The stage also decodes the extended immediate and the
// branch target. Every fetch result is registered into a single output slot
// that uses a valid/ready handshake and can be flushed.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   i_in_valid/o_in_ready  fetch-side handshake (o_in_ready is combinational)
//   i_in_inst, i_in_pc     instruction word and its address
//   i_in_is_st             op2 reads inst[25:22] (store data register)
//   i_in_is_ret            op1 reads RA_IDX (return address register)
//   i_flush                drop the held and the incoming instruction
//   i_wb_en/addr/data      register file write port
//   o_out_valid/i_out_ready execute-side handshake
//   o_out_*                registered instruction, pc, operands, imm, target
//
// Parameter constraints: DATA_W >= 32, NUM_REGS == 16 (4-bit specifiers).
// ---------------------------------------------------------------------------

// One register-file read port with optional writeback forwarding.
module of_stage_p_rdport #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] i_regs,
  input  logic [3:0]                      i_src,
  input  logic                            i_wb_en,
  input  logic [3:0]                      i_wb_addr,
  input  logic [DATA_W-1:0]               i_wb_data,
  output logic [DATA_W-1:0]               o_data
);
  logic w_hit;

  // The hit is always computed. BYPASS only gates its use, so a BYPASS=0
  // build reads the stored (pre-write) value in a write+read cycle.
  assign w_hit  = i_wb_en && (i_wb_addr == i_src);
  assign o_data = (BYPASS && w_hit) ? i_wb_data : i_regs[i_src];
endmodule

module of_stage_p #(
  parameter int          DATA_W   = 32,
  parameter int          NUM_REGS = 16,
  parameter int          RA_IDX   = 15,
  parameter int          SP_IDX   = 14,
  parameter logic [31:0] SP_INIT  = 32'h0000_FFFC,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch side
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_in_inst,
  input  logic [DATA_W-1:0] i_in_pc,
  input  logic              i_in_is_st,
  input  logic              i_in_is_ret,
  input  logic              i_flush,
  // writeback port
  input  logic              i_wb_en,
  input  logic [3:0]        i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  // execute side
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_inst,
  output logic [DATA_W-1:0] o_out_pc,
  output logic [DATA_W-1:0] o_out_op1,
  output logic [DATA_W-1:0] o_out_op2,
  output logic [DATA_W-1:0] o_out_immx,
  output logic [DATA_W-1:0] o_out_branch_target
);
  localparam int NRD = 2;

  typedef struct packed {
    logic [31:0]       inst;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] immx;
    logic [DATA_W-1:0] tgt;
  } ofp_out_t;

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NRD-1:0][3:0]             w_src;
  logic [NRD-1:0][DATA_W-1:0]      w_rd;
  logic [DATA_W-1:0]               w_immx;
  logic [DATA_W-1:0]               w_boff;
  ofp_out_t                        w_nxt;
  ofp_out_t                        r_out;
  logic                            r_valid;
  logic                            w_xfer;

  // ---------------------------------------------------------------- regfile
  // Writes ignore the handshake and flush. Only SP has a non-zero reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (k == SP_IDX) r_regs[k] <= DATA_W'(SP_INIT);
        else             r_regs[k] <= '0;
      end
    end else if (i_wb_en) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  // ------------------------------------------------------------ read ports
  assign w_src[0] = i_in_is_ret ? 4'(RA_IDX) : i_in_inst[21:18];
  assign w_src[1] = i_in_is_st  ? i_in_inst[25:22] : i_in_inst[17:14];

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    of_stage_p_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .BYPASS   (BYPASS)
    ) u_rd (
      .i_regs    (r_regs),
      .i_src     (w_src[g]),
      .i_wb_en   (i_wb_en),
      .i_wb_addr (i_wb_addr),
      .i_wb_data (i_wb_data),
      .o_data    (w_rd[g])
    );
  end

  // ------------------------------------------------------------- immediate
  // inst[17:16] modifier: 01 = unsigned, 10 = upper half, else signed.
  always_comb begin
    w_immx = {{(DATA_W-16){i_in_inst[15]}}, i_in_inst[15:0]};
    case (i_in_inst[17:16])
      2'b01:   w_immx = {{(DATA_W-16){1'b0}}, i_in_inst[15:0]};
      2'b10:   w_immx = {{(DATA_W-32){1'b0}}, i_in_inst[15:0], 16'h0000};
      default: ;
    endcase
  end

  // Word offset scaled to bytes. The 29-bit signed value is sign-extended and
  // the add wraps modulo 2^DATA_W.
  assign w_boff = {{(DATA_W-29){i_in_inst[26]}}, i_in_inst[26:0], 2'b00};

  always_comb begin
    w_nxt.inst = i_in_inst;
    w_nxt.pc   = i_in_pc;
    w_nxt.op1  = w_rd[0];
    w_nxt.op2  = w_rd[1];
    w_nxt.immx = w_immx;
    w_nxt.tgt  = i_in_pc + w_boff;
  end

  // ----------------------------------------------------------- output slot
  assign o_in_ready = !r_valid || i_out_ready;
  assign w_xfer     = i_in_valid && o_in_ready && !i_flush;

  // The payload loads only on a transfer, so a stalled slot keeps the operand
  // values it captured even if the register file is written later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_xfer) r_out <= w_nxt;
      // Flush wins over a simultaneous transfer and also kills a held entry.
      if (i_flush)          r_valid <= 1'b0;
      else if (w_xfer)      r_valid <= 1'b1;
      else if (i_out_ready) r_valid <= 1'b0;
    end
  end

  assign o_out_valid         = r_valid;
  assign o_out_inst          = r_out.inst;
  assign o_out_pc            = r_out.pc;
  assign o_out_op1           = r_out.op1;
  assign o_out_op2           = r_out.op2;
  assign o_out_immx          = r_out.immx;
  assign o_out_branch_target = r_out.tgt;
endmodule
